fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one imem request at a time from the PC,
// loads the returned instruction and its PC into the IF/ID register, holds it
// across decode stalls and discards in-flight fetches on a branch flush.
module fetch_stage #(
  parameter int                   ADDR_W    = 64,
  parameter int                   INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'hD503201F
) (
  input  logic               clk,
  input  logic               reset,          // active-low, asynchronous
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_advance,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               flush,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t             state, next_state;
  logic [ADDR_W-1:0]  req_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic               hold_vld;
  logic               load;          // an instruction enters IF/ID this edge
  logic               capture;       // response parked in the hold buffer
  logic [INSTR_W-1:0] load_instr;
  logic               handshake;

  // Request is masked while reset is held so nothing leaks out during reset.
  assign imem_req_valid = (state == REQ) && reset;
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;
  // The PC only steps on the edge an instruction actually lands in IF/ID.
  assign pc_advance     = load;

  // Next-state and load decode; flush always wins and suppresses any load.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    capture    = 1'b0;
    load_instr = imem_rsp_data;
    case (state)
      REQ: begin
        if (handshake) next_state = flush ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (flush) begin
            next_state = REQ;            // response dies with the flush
          end else if (stall) begin
            capture    = 1'b1;
            next_state = HOLD;
          end else begin
            load       = 1'b1;
            next_state = REQ;
          end
        end else if (flush) begin
          next_state = DROP;             // response still in flight
        end
      end
      HOLD: begin
        if (flush) begin
          next_state = REQ;
        end else if (!stall && hold_vld) begin
          load       = 1'b1;
          load_instr = hold_instr;
          next_state = REQ;
        end
      end
      DROP: begin
        if (imem_rsp_valid) next_state = REQ;   // swallow the stale response
      end
      default: next_state = REQ;
    endcase
  end

  // Fetch control state, request PC and hold buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= REQ;
      req_pc     <= '0;
      hold_instr <= '0;
      hold_vld   <= 1'b0;
    end else begin
      state <= next_state;
      if (handshake) req_pc <= pc;
      if (capture) begin
        hold_instr <= imem_rsp_data;
        hold_vld   <= 1'b1;
      end else if (flush || load) begin
        hold_vld   <= 1'b0;
      end
    end
  end

  // IF/ID register: flush clears, stall holds, otherwise load or bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (load) begin
        if_id_valid <= 1'b1;
        if_id_instr <= load_instr;
        if_id_pc    <= req_pc;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the straight-line fetch,
// ready back-pressure and stall cases, then hand-written flush/reset sequences.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        pc_advance, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [63:0] imem_req_addr, if_id_pc;
  logic [31:0] imem_rsp_data, if_id_instr;
  logic        stall, flush, if_id_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_advance(pc_advance),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .stall(stall), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        rdy, rv;
    logic [31:0] data;
    logic        stall, flush;
    logic        adv, rq;
    logic [63:0] addr;
    logic        v;
    logic [31:0] instr;
    logic [63:0] ipc;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs at the falling edge; checks happen 1 time unit later.
  task automatic drive(input logic [63:0] p, input logic rdy, input logic rv,
                       input logic [31:0] d, input logic st, input logic fl);
    @(negedge clk);
    pc = p; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = d;
    stall = st; flush = fl;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic adv, input logic rq,
                         input logic [63:0] addr, input logic v,
                         input logic [31:0] ins, input logic [63:0] ipc);
    chk({tag, ".pc_advance"}, {63'd0, pc_advance}, {63'd0, adv});
    chk({tag, ".req_valid"}, {63'd0, imem_req_valid}, {63'd0, rq});
    chk({tag, ".req_addr"}, imem_req_addr, addr);
    chk({tag, ".if_id_valid"}, {63'd0, if_id_valid}, {63'd0, v});
    chk({tag, ".if_id_instr"}, {32'd0, if_id_instr}, {32'd0, ins});
    chk({tag, ".if_id_pc"}, if_id_pc, ipc);
  endtask

  initial begin
    // pc rdy rv data stall flush | adv rq addr v instr ipc
    // Two back-to-back fetches, one response a cycle after each request.
    tbl[0]  = '{64'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'd0,  1'b0, NOP,          64'd0};
    tbl[1]  = '{64'd0,  1'b1, 1'b1, 32'h8B020020, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0,  1'b0, NOP,          64'd0};
    tbl[2]  = '{64'd4,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'd4,  1'b1, 32'h8B020020, 64'd0};
    tbl[3]  = '{64'd4,  1'b1, 1'b1, 32'h8B030041, 1'b0, 1'b0, 1'b1, 1'b0, 64'd4,  1'b0, NOP,          64'd0};
    // Memory not ready for 3 cycles at pc 8.
    tbl[4]  = '{64'd8,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'd8,  1'b1, 32'h8B030041, 64'd4};
    tbl[5]  = '{64'd8,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'd8,  1'b0, NOP,          64'd4};
    tbl[6]  = '{64'd8,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'd8,  1'b0, NOP,          64'd4};
    tbl[7]  = '{64'd8,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'd8,  1'b0, NOP,          64'd4};
    tbl[8]  = '{64'd8,  1'b0, 1'b1, 32'hAA000008, 1'b0, 1'b0, 1'b1, 1'b0, 64'd8,  1'b0, NOP,          64'd4};
    // Response for pc 12 arrives under stall, released 2 cycles later.
    tbl[9]  = '{64'd12, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'd12, 1'b1, 32'hAA000008, 64'd8};
    tbl[10] = '{64'd12, 1'b0, 1'b1, 32'h91000421, 1'b1, 1'b0, 1'b0, 1'b0, 64'd12, 1'b0, NOP,          64'd8};
    tbl[11] = '{64'd12, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 64'd12, 1'b0, NOP,          64'd8};
    tbl[12] = '{64'd12, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 64'd12, 1'b0, NOP,          64'd8};
    // Stall with a live instruction: IF/ID must hold it.
    tbl[13] = '{64'd16, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 64'd16, 1'b1, 32'h91000421, 64'd12};
    tbl[14] = '{64'd16, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'd16, 1'b1, 32'h91000421, 64'd12};

    reset = 1'b0; pc = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; stall = 1'b0; flush = 1'b0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 64'd0, 1'b0, NOP, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].pc, tbl[i].rdy, tbl[i].rv, tbl[i].data, tbl[i].stall, tbl[i].flush);
      chk_all($sformatf("vec%0d", i), tbl[i].adv, tbl[i].rq, tbl[i].addr,
              tbl[i].v, tbl[i].instr, tbl[i].ipc);
    end

    // Flush in WAIT before the response; late 0xDEADBEEF must be dropped.
    drive(64'd48, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("flA.req_valid", {63'd0, imem_req_valid}, 64'd1);
    drive(64'd48, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("flB.pc_advance", {63'd0, pc_advance}, 64'd0);
    drive(64'd52, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk_all("flC", 1'b0, 1'b0, 64'd52, 1'b0, NOP, 64'd12);
    drive(64'd52, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("flD", 1'b0, 1'b1, 64'd52, 1'b0, NOP, 64'd12);
    drive(64'd52, 1'b0, 1'b1, 32'h8B000000, 1'b0, 1'b0);
    chk_all("flE", 1'b1, 1'b0, 64'd52, 1'b0, NOP, 64'd12);

    // Fetch under stall into HOLD, then flush+stall together.
    drive(64'd56, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_all("hF", 1'b0, 1'b1, 64'd56, 1'b1, 32'h8B000000, 64'd52);
    drive(64'd56, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0);
    chk_all("hG", 1'b0, 1'b0, 64'd56, 1'b1, 32'h8B000000, 64'd52);
    drive(64'd56, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_all("hH", 1'b0, 1'b0, 64'd56, 1'b1, 32'h8B000000, 64'd52);
    drive(64'd56, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("hI", 1'b0, 1'b1, 64'd56, 1'b0, NOP, 64'd52);
    drive(64'd56, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("hJ", 1'b0, 1'b1, 64'd56, 1'b0, NOP, 64'd52);
    drive(64'd56, 1'b0, 1'b1, 32'h0000AAAA, 1'b0, 1'b0);
    chk_all("hK", 1'b1, 1'b0, 64'd56, 1'b0, NOP, 64'd52);
    drive(64'd60, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("hL", 1'b0, 1'b1, 64'd60, 1'b1, 32'h0000AAAA, 64'd56);

    // Async reset mid-WAIT, then a stale response after release.
    @(posedge clk);
    #2;
    imem_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk_all("rst", 1'b0, 1'b0, 64'd60, 1'b0, NOP, 64'd0);
    drive(64'd60, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk_all("stale", 1'b0, 1'b1, 64'd60, 1'b0, NOP, 64'd0);
    drive(64'd60, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("post", 1'b0, 1'b1, 64'd60, 1'b0, NOP, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
